univ_reg: RTL

UNIV_REG -- requirements
Module: univ_reg

---
 rtl/univ_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/univ_reg.sv
// ----------------------------------------------------------------------------
// univ_reg -- universal shift / rotate / load register with carry-out flag.
//
// Each enabled rising clock edge applies one operation selected by Mode. The
// operations are hold, parallel load, shift left or right with a serial input,
// rotate left or right, and (optionally) increment or decrement. Co records the
// bit shifted or rotated out, or the wrap-around of the counter.
//
// Ports:
//   Clk   in   1      clock, rising edge
//   Rst   in   1      synchronous active-high reset (Q <= RESET_VAL, Co <= 0)
//   En    in   1      update enable; 0 freezes Q and Co
//   Mode  in   3      operation select
//   D     in   WIDTH  parallel load data
//   SinL  in   1      serial bit entering bit 0 on shift left
//   SinR  in   1      serial bit entering bit WIDTH-1 on shift right
//   Q     out  WIDTH  registered value
//   Qn    out  WIDTH  ~Q (combinational from Q)
//   Co    out  1      registered carry / shift-out flag
//   Z     out  1      1 when Q is all zeros (combinational from Q)
//
// Configuration macro: UNIV_REG_COUNT_EN
//   defined   -> Mode 110 increments and Mode 111 decrements Q (mod 2^WIDTH).
//   undefined -> Modes 110 and 111 hold, and no adder/subtractor is built.
// ----------------------------------------------------------------------------
module univ_reg #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SinL,
  input  logic             SinR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             Co,
  output logic             Z
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_co_nxt;

  // Next-state selection: every path starts from "hold" so Q and Co only move
  // when an enabled operation explicitly says so.
  always_comb begin
    w_q_nxt  = r_q;
    w_co_nxt = r_co;
    if (En) begin
      case (Mode)
        MODE_HOLD: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
        MODE_LOAD: begin
          w_q_nxt  = D;
          w_co_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], SinL};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_nxt  = {SinR, r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
        MODE_ROL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_ROR: begin
          w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
`ifdef UNIV_REG_COUNT_EN
        // Co flags the wrap: all-ones -> 0 on increment, 0 -> all-ones on decrement.
        MODE_INC: begin
          w_q_nxt  = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
          w_co_nxt = &r_q;
        end
        MODE_DEC: begin
          w_q_nxt  = r_q - {{(WIDTH-1){1'b0}}, 1'b1};
          w_co_nxt = ~|r_q;
        end
`else
        // Counting is not built in this configuration; these codes hold.
        MODE_INC: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
        MODE_DEC: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
`endif
        default: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
      endcase
    end else begin
      w_q_nxt  = r_q;
      w_co_nxt = r_co;
    end
  end

  // State register: synchronous reset overrides enable and mode.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q  <= RESET_VAL;
      r_co <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_co <= w_co_nxt;
    end
  end

  assign Q  = r_q;
  assign Co = r_co;
  // Qn and Z depend on the register only, never on D or Mode.
  assign Qn = ~r_q;
  assign Z  = ~|r_q;

endmodule
